// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: wide add via one shared 4-bit ripple adder.
// Ports: clk, rst_n, start, a, b, cin, [sub if SERIAL_ADD_SUB_EN], busy, done, sum.
module nibble_serial_adder_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
`ifdef SERIAL_ADD_SUB_EN
  input  logic                 sub,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES:0]   sum
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = $clog2(NIBBLES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state;
  logic [IW-1:0] idx;
  logic          carry;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [3:0]    a_nib;
  logic [3:0]    b_nib;
  logic [4:0]    nsum;
  logic          rc;
  logic          last;

  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IW'(i)) begin
        a_nib = a_reg[4*i +: 4];
        b_nib = b_reg[4*i +: 4];
      end
    end
  end

  // The shared narrow adder, ripple-carry bit by bit.
  always_comb begin
    nsum = '0;
    rc   = carry;
    for (int i = 0; i < 4; i++) begin
      nsum[i] = a_nib[i] ^ b_nib[i] ^ rc;
      rc = (a_nib[i] & b_nib[i]) |
           (rc & (a_nib[i] ^ b_nib[i]));
    end
    nsum[4] = rc;
  end

  assign last = (idx == IW'(NIBBLES - 1));
  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      idx   <= '0;
      carry <= 1'b0;
      a_reg <= '0;
      b_reg <= '0;
      sum   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            a_reg <= a;
`ifdef SERIAL_ADD_SUB_EN
            // a - b == a + ~b + 1
            b_reg <= sub ? ~b : b;
            carry <= sub | cin;
`else
            b_reg <= b;
            carry <= cin;
`endif
            idx   <= '0;
            sum   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IW'(i)) begin
              sum[4*i +: 4] <= nsum[3:0];
            end
          end
          carry <= nsum[4];
          if (last) begin
            sum[W] <= nsum[4];
            idx    <= '0;
            state  <= S_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl: randomized self-checking bench.
// Reference model is plain integer add/subtract on full-width operands.
module tb_nibble_serial_adder_ctrl;

  localparam int N = 4;
  localparam int W = 4 * N;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         busy;
  logic         done;
  logic [W:0]   sum;

  int checks;
  int errors;

  nibble_serial_adder_ctrl #(.NIBBLES(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W:0] model(
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic         c,
    input logic         s
  );
    logic [W:0] r;
    if (s) begin
      r[W-1:0] = x - y;
      r[W]     = (x >= y);
    end else begin
      r = {1'b0, x} + {1'b0, y} + (W+1)'(c);
    end
    return r;
  endfunction

  // Drives one request, then watches N+3 cycles while
  // scrambling the operand inputs (they must not matter).
  task automatic do_op(
    input  logic [W-1:0] ia,
    input  logic [W-1:0] ib,
    input  logic         ic,
    output int           lat,
    output int           dcnt,
    output int           bcnt,
    output logic [W:0]   sd
  );
    lat  = 0;
    dcnt = 0;
    bcnt = 0;
    sd   = '0;
    @(negedge clk);
    a = ia;
    b = ib;
    cin = ic;
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= N + 3; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (done) begin
        dcnt++;
        if (lat == 0) begin
          lat = k;
          sd  = sum;
        end
      end
      if (busy) bcnt++;
      a   = W'($urandom);
      b   = W'($urandom);
      cin = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b1;
    a = 16'hFFFF;
    b = 16'hFFFF;
    cin = 1'b1;
    sub = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b expected 0", busy);
    end
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: got %b expected 0", done);
    end
    checks++;
    if (sum !== '0) begin
      errors++;
      $display("FAIL reset_sum: got %h expected 0", sum);
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_vectors;
    logic [W-1:0] va [3];
    logic [W-1:0] vb [3];
    logic         vc [3];
    logic [W:0]   ve [3];
    int lat, dcnt, bcnt;
    logic [W:0] sd;
    va = '{16'hAAAA, 16'hFFFF, 16'hFFFF};
    vb = '{16'h5555, 16'h0001, 16'hFFFF};
    vc = '{1'b0, 1'b0, 1'b1};
    ve = '{17'h0FFFF, 17'h10000, 17'h1FFFF};
    sub = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], vc[i], lat, dcnt, bcnt, sd);
      checks++;
      if (sd !== ve[i]) begin
        errors++;
        $display("FAIL vec%0d_sum: got %h expected %h",
                 i, sd, ve[i]);
      end
      checks++;
      if (lat != N + 1) begin
        errors++;
        $display("FAIL vec%0d_latency: got %0d expected %0d",
                 i, lat, N + 1);
      end
      checks++;
      if (bcnt != N + 1) begin
        errors++;
        $display("FAIL vec%0d_busy_cycles: got %0d expected %0d",
                 i, bcnt, N + 1);
      end
      checks++;
      if (dcnt != 1) begin
        errors++;
        $display("FAIL vec%0d_done_count: got %0d expected 1",
                 i, dcnt);
      end
      checks++;
      if (sum !== ve[i]) begin
        errors++;
        $display("FAIL vec%0d_hold: got %h expected %h",
                 i, sum, ve[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int d1, d2, dcnt;
    logic [W:0] s1, s2, e1, e2;
    d1 = 0;
    d2 = 0;
    dcnt = 0;
    s1 = '0;
    s2 = '0;
    sub = 1'b0;
    e1 = model(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    e2 = model(16'h0001, 16'h0002, 1'b0, 1'b0);
    @(negedge clk);
    a = 16'hFFFF;
    b = 16'hFFFF;
    cin = 1'b1;
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 2 * N + 5; k++) begin
      @(negedge clk);
      if (k == 1) begin
        a = 16'h0001;
        b = 16'h0002;
        cin = 1'b0;
      end
      if (k == N + 3) start = 1'b0;
      if (done) begin
        dcnt++;
        if (d1 == 0) begin
          d1 = k;
          s1 = sum;
        end else if (d2 == 0) begin
          d2 = k;
          s2 = sum;
        end
      end
    end
    checks++;
    if (dcnt != 2) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d expected 2", dcnt);
    end
    checks++;
    if (d1 != N + 1 || s1 !== e1) begin
      errors++;
      $display("FAIL b2b_first: got t%0d %h expected t%0d %h",
               d1, s1, N + 1, e1);
    end
    checks++;
    if (d2 != 2 * N + 3 || s2 !== e2) begin
      errors++;
      $display("FAIL b2b_second: got t%0d %h expected t%0d %h",
               d2, s2, 2 * N + 3, e2);
    end
  endtask

  task automatic test_mid_run_start;
    int lat, dcnt, bcnt;
    logic [W:0] sd, e;
    lat = 0;
    dcnt = 0;
    bcnt = 0;
    sd = '0;
    sub = 1'b0;
    e = model(16'h1357, 16'h2468, 1'b1, 1'b0);
    @(negedge clk);
    a = 16'h1357;
    b = 16'h2468;
    cin = 1'b1;
    start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= N + 6; k++) begin
      @(negedge clk);
      if (k == 1) start = 1'b0;
      if (k == 2) begin
        start = 1'b1;
        a = 16'h0F0F;
        b = 16'h7777;
      end
      if (k == 3) start = 1'b0;
      if (done) begin
        dcnt++;
        if (lat == 0) begin
          lat = k;
          sd = sum;
        end
      end
      if (busy) bcnt++;
    end
    checks++;
    if (dcnt != 1 || lat != N + 1) begin
      errors++;
      $display("FAIL midrun_done: got %0d at t%0d expected 1 at t%0d",
               dcnt, lat, N + 1);
    end
    checks++;
    if (sd !== e) begin
      errors++;
      $display("FAIL midrun_sum: got %h expected %h", sd, e);
    end
    checks++;
    if (bcnt != N + 1) begin
      errors++;
      $display("FAIL midrun_busy: got %0d expected %0d", bcnt, N + 1);
    end
  endtask

  task automatic test_reset_mid_run;
    int dcnt, bcnt, lat, d2, b2;
    logic [W:0] sd, e;
    dcnt = 0;
    bcnt = 0;
    sub = 1'b0;
    @(negedge clk);
    a = 16'h8888;
    b = 16'h8888;
    cin = 1'b0;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sum !== '0) begin
      errors++;
      $display("FAIL async_reset: got busy=%b done=%b sum=%h expected 0 0 0",
               busy, done, sum);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < N + 3; k++) begin
      @(negedge clk);
      if (done) dcnt++;
      if (busy) bcnt++;
    end
    checks++;
    if (dcnt != 0 || bcnt != 0) begin
      errors++;
      $display("FAIL post_reset_idle: got done=%0d busy=%0d expected 0 0",
               dcnt, bcnt);
    end
    e = model(16'h0123, 16'hFEDC, 1'b1, 1'b0);
    do_op(16'h0123, 16'hFEDC, 1'b1, lat, d2, b2, sd);
    checks++;
    if (sd !== e || lat != N + 1) begin
      errors++;
      $display("FAIL post_reset_op: got %h t%0d expected %h t%0d",
               sd, lat, e, N + 1);
    end
  endtask

  task automatic test_random;
    int lat, dcnt, bcnt;
    logic [W:0] sd, e;
    logic [W-1:0] ra, rb;
    logic rcin;
    for (int i = 0; i < 24; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      if (i % 4 == 0) rb = ~ra;
      rcin = 1'($urandom_range(0, 1));
`ifdef SERIAL_ADD_SUB_EN
      sub = 1'($urandom_range(0, 1));
`else
      sub = 1'b0;
`endif
      e = model(ra, rb, rcin, sub);
      do_op(ra, rb, rcin, lat, dcnt, bcnt, sd);
      checks++;
      if (sd !== e || lat != N + 1 || dcnt != 1) begin
        errors++;
        $display("FAIL rand%0d: got %h t%0d n%0d expected %h t%0d n1",
                 i, sd, lat, dcnt, e, N + 1);
      end
    end
    sub = 1'b0;
  endtask

`ifdef SERIAL_ADD_SUB_EN
  task automatic test_sub;
    int lat, dcnt, bcnt;
    logic [W:0] sd;
    sub = 1'b1;
    do_op(16'h1234, 16'h0234, 1'b0, lat, dcnt, bcnt, sd);
    checks++;
    if (sd !== 17'h11000) begin
      errors++;
      $display("FAIL sub_noborrow: got %h expected 11000", sd);
    end
    do_op(16'h0001, 16'h0002, 1'b1, lat, dcnt, bcnt, sd);
    checks++;
    if (sd !== 17'h0FFFF) begin
      errors++;
      $display("FAIL sub_borrow: got %h expected 0ffff", sd);
    end
    sub = 1'b0;
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_vectors();
    test_back_to_back();
    test_mid_run_start();
    test_reset_mid_run();
`ifdef SERIAL_ADD_SUB_EN
    test_sub();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
